// File: rtl/vga_tag_pkg.sv
// vga_tag_pkg
// Shared video-timing defaults and the scheduler state type used by
// frame_update_sched and its testbench.
//   H_TOTAL_DEF  : pixel clocks per line
//   V_TOTAL_DEF  : lines per frame
//   V_ACTIVE_DEF : visible lines; lines V_ACTIVE..V_TOTAL-1 form the blanking window
package vga_tag_pkg;

    localparam int unsigned H_TOTAL_DEF  = 800;
    localparam int unsigned V_TOTAL_DEF  = 525;
    localparam int unsigned V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_GRANT = 2'd2,
        S_DRAIN = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
// Two-way round-robin selector with a persistent priority pointer.
// The pointer names the player favoured on a tie and flips to the other
// player whenever a grant is issued, so the player not served last wins.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (pointer -> player 0)
//   pending_i   : outstanding requests, bit0 = player 0
//   update_i    : a grant is being issued this cycle; advance the pointer
//   sel_o       : one-hot-or-zero selection from pending_i
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pending_i,
    input  logic       update_i,
    output logic [1:0] sel_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        sel_o = 2'b00;
        case (pending_i)
            2'b01:   sel_o = 2'b01;
            2'b10:   sel_o = 2'b10;
            2'b11:   sel_o = ptr_q ? 2'b10 : 2'b01;
            default: sel_o = 2'b00;
        endcase
    end

    // Serving player 0 favours player 1 next time, and vice versa.
    always_comb begin
        ptr_d = ptr_q;
        if (update_i && (sel_o != 2'b00)) begin
            ptr_d = sel_o[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/frame_update_sched.sv
// frame_update_sched
// Grants two players exclusive, one-at-a-time access to shared position
// registers during the vertical blanking window, at most once per frame.
// Ports:
//   clk, rst_n   : pixel clock, asynchronous active-low reset
//   h_count      : horizontal pixel counter 0..H_TOTAL-1
//   v_count      : vertical line counter 0..V_TOTAL-1
//   req          : per-player update request (level), sampled at window open
//   done         : per-player completion strobe, honoured only for the granted player
//   clr_overrun  : clears the sticky overrun flag
//   grant        : one-hot-or-zero grant
//   frame_tick   : one-clock pulse the clock after window open
//   busy         : scheduler is outside IDLE
//   overrun      : sticky; work left unfinished at window close or grant timeout
// Build option: FRAME_SCHED_TIMEOUT_EN adds a grant timeout of TIMEOUT clocks.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | outside the window or waiting for the next window open
// ARB     | pick the next pending player, or drain if nothing pending
// GRANT   | one player holds grant until done (or timeout)
// DRAIN   | all pending work finished; wait for window close
module frame_update_sched
    import vga_tag_pkg::*;
#(
    parameter int unsigned H_TOTAL  = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL  = V_TOTAL_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] h_count,
    input  logic [15:0] v_count,
    input  logic [1:0]  req,
    input  logic [1:0]  done,
    input  logic        clr_overrun,
    output logic [1:0]  grant,
    output logic        frame_tick,
    output logic        busy,
    output logic        overrun
);

    localparam logic [15:0] H_LAST  = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST  = 16'(V_TOTAL - 1);
    localparam logic [15:0] V_OPEN  = 16'(V_ACTIVE);

    sched_state_e state_q, state_d;
    logic [1:0]   pending_q, pending_d;
    logic [1:0]   grant_q, grant_d;
    logic         tick_q;
    logic         overrun_q, overrun_d;

    logic         win_open, win_close;
    logic         done_hit, tmo_hit;
    logic [1:0]   pending_left;
    logic [1:0]   arb_sel;
    logic         arb_upd;
    logic         ovr_set;

    assign win_open  = (h_count == 16'd0)  && (v_count == V_OPEN);
    assign win_close = (h_count == H_LAST) && (v_count == V_LAST);

    assign done_hit = (state_q == S_GRANT) && ((done & grant_q) != 2'b00);

    // Pending set once the current grant has ended, whether by done or by timeout.
    assign pending_left = (done_hit || tmo_hit) ? (pending_q & ~grant_q) : pending_q;

`ifdef FRAME_SCHED_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Preloaded outside GRANT so the first GRANT clock already holds TIMEOUT-1;
    // reaching zero therefore marks the TIMEOUT-th granted clock.
    always_comb begin
        tmo_d = TMO_W'(TIMEOUT - 1);
        if (state_q == S_GRANT) begin
            tmo_d = (tmo_q != '0) ? (tmo_q - 1'b1) : tmo_q;
        end
    end

    assign tmo_hit = (state_q == S_GRANT) && (tmo_q == '0) && !done_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    rr_arbiter_2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .pending_i (pending_q),
        .update_i  (arb_upd),
        .sel_o     (arb_sel)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        arb_upd   = 1'b0;
        ovr_set   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_open) begin
                    state_d   = S_ARB;
                    pending_d = req;
                end
            end
            S_ARB: begin
                if (pending_q == 2'b00) begin
                    state_d = S_DRAIN;
                end else begin
                    grant_d = arb_sel;
                    arb_upd = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (done_hit || tmo_hit) begin
                    grant_d   = 2'b00;
                    pending_d = pending_left;
                    ovr_set   = tmo_hit;
                    state_d   = S_ARB;
                end
            end
            S_DRAIN: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Window close wins over everything; a done arriving on this same
        // cycle still retires its player and does not count as overrun.
        if (win_close) begin
            state_d   = S_IDLE;
            grant_d   = 2'b00;
            pending_d = 2'b00;
            arb_upd   = 1'b0;
            ovr_set   = tmo_hit || (pending_left != 2'b00);
        end
    end

    always_comb begin
        overrun_d = overrun_q;
        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= 2'b00;
            grant_q   <= 2'b00;
            tick_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            tick_q    <= win_open;
            overrun_q <= overrun_d;
        end
    end

    assign grant      = grant_q;
    assign frame_tick = tick_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// tb_frame_update_sched
// Scoreboard bench: stimulus pushes the expected grant pulses (player, length
// in clocks) into a queue; a monitor measures every grant pulse the DUT
// produces and pops/compares. frame_tick is checked against a reference
// computed from the same h/v counters. Small video timing keeps runs short:
// 24 clocks per line, 10 lines, window = line 9 (24 clocks), TIMEOUT = 16.
module tb_frame_update_sched;

    localparam int H   = 24;
    localparam int V   = 10;
    localparam int VA  = 9;
    localparam int TMO = 16;
    localparam int BOUND = 600;

    logic        clk;
    logic        rst_n;
    logic [15:0] h_count;
    logic [15:0] v_count;
    logic [1:0]  req;
    logic [1:0]  done;
    logic        clr_overrun;
    logic [1:0]  grant;
    logic        frame_tick;
    logic        busy;
    logic        overrun;

    typedef struct {
        logic [1:0] g;
        int         len;
    } pulse_t;

    pulse_t     exp_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         onehot_bad = 0;
    logic       exp_tick = 1'b0;
    logic [1:0] mon_prev = 2'b00;
    int         mon_len  = 0;

    frame_update_sched #(
        .H_TOTAL  (H),
        .V_TOTAL  (V),
        .V_ACTIVE (VA),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_count     (h_count),
        .v_count     (v_count),
        .req         (req),
        .done        (done),
        .clr_overrun (clr_overrun),
        .grant       (grant),
        .frame_tick  (frame_tick),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Video timing generator, advanced on the falling edge.
    initial begin
        h_count = '0;
        v_count = '0;
        forever begin
            @(negedge clk);
            if (h_count == 16'(H - 1)) begin
                h_count = '0;
                v_count = (v_count == 16'(V - 1)) ? 16'd0 : v_count + 16'd1;
            end else begin
                h_count = h_count + 16'd1;
            end
        end
    end

    // frame_tick reference: high the clock after h=0, v=VA is seen out of reset.
    initial forever begin
        @(posedge clk);
        exp_tick = rst_n && (h_count == 16'd0) && (v_count == 16'(VA));
    end

    initial forever begin
        @(negedge clk);
        if (exp_tick || frame_tick) check("frame_tick", {31'd0, frame_tick}, {31'd0, exp_tick});
    end

    task automatic end_pulse(input logic [1:0] g, input int len);
        pulse_t e;
        if (exp_q.size() == 0) begin
            check("grant_unexpected", {30'd0, g}, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("grant_value", {30'd0, g}, {30'd0, e.g});
        check("grant_len", len, e.len);
    endtask

    // Grant monitor: measures each pulse in clocks and scores it.
    initial forever begin
        @(negedge clk);
        if ($countones(grant) > 1) onehot_bad++;
        if (grant !== mon_prev) begin
            if (mon_prev != 2'b00) end_pulse(mon_prev, mon_len);
            mon_len = 1;
        end else begin
            mon_len++;
        end
        mon_prev = grant;
    end

    task automatic wait_grant(output bit ok);
        int n = 0;
        while (grant == 2'b00 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        ok = (grant != 2'b00);
        check("grant_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("idle_seen", {31'd0, busy}, 32'd0);
    endtask

    // Returns on the falling edge just before the clock that sees window close.
    task automatic wait_close_m1();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(h_count == 16'(H - 2) && v_count == 16'(V - 1)) && n < BOUND);
        check("close_seen", {31'd0, (h_count == 16'(H - 2))}, 32'd1);
        @(negedge clk);
    endtask

    // Hold the grant for len clocks then strobe done; optionally strobe done
    // for the other player on the first granted clock (must be ignored).
    task automatic serve(input int len, input bit spur);
        bit ok;
        logic [1:0] g;
        wait_grant(ok);
        if (!ok) return;
        g = grant;
        if (spur) done = ~g;
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            done = 2'b00;
        end
        done = g;
        @(negedge clk);
        done = 2'b00;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        @(negedge clk);
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
    endtask

    initial begin
        bit ok;
        bit early;
        rst_n = 1'b0;
        req = 2'b00;
        done = 2'b00;
        clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant",   {30'd0, grant},      32'd0);
        check("rst_tick",    {31'd0, frame_tick}, 32'd0);
        check("rst_busy",    {31'd0, busy},       32'd0);
        check("rst_overrun", {31'd0, overrun},    32'd0);
        rst_n = 1'b1;

        // Both players every frame: P0 then P1 each time; spurious done in frame 0.
        req = 2'b11;
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back('{2'b01, 4});
            exp_q.push_back('{2'b10, 5});
            serve(4, f == 0);
            serve(5, 1'b0);
            check("rr_busy_drain", {31'd0, busy}, 32'd1);
            wait_idle();
            check("rr_overrun", {31'd0, overrun}, 32'd0);
        end

        // Single player, done after 10 clocks, then drain to close.
        req = 2'b01;
        exp_q.push_back('{2'b01, 10});
        serve(10, 1'b0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        check("drain_busy",    {31'd0, busy},    32'd1);
        check("drain_grant",   {30'd0, grant},   32'd0);
        check("drain_overrun", {31'd0, overrun}, 32'd0);
        wait_idle();
        check("single_overrun", {31'd0, overrun}, 32'd0);

        // Pointer persisted (P0 last served): P1 first; P0 then finishes on the close cycle.
        req = 2'b11;
        exp_q.push_back('{2'b10, 10});
        exp_q.push_back('{2'b01, 11});
        serve(10, 1'b0);
        req = 2'b00;
        wait_grant(ok);
        wait_close_m1();
        done = 2'b01;
        @(negedge clk);
        done = 2'b00;
        check("close_done_grant",   {30'd0, grant},   32'd0);
        check("close_done_busy",    {31'd0, busy},    32'd0);
        check("close_done_overrun", {31'd0, overrun}, 32'd0);

        // Player never finishes.
        req = 2'b01;
`ifdef FRAME_SCHED_TIMEOUT_EN
        exp_q.push_back('{2'b01, TMO});
        wait_grant(ok);
        req = 2'b00;
        while (grant != 2'b00 && ok) @(negedge clk);
        @(negedge clk);
        check("tmo_overrun", {31'd0, overrun}, 32'd1);
        check("tmo_busy",    {31'd0, busy},    32'd1);
        clr_pulse();
        wait_idle();
`else
        exp_q.push_back('{2'b01, 22});
        wait_grant(ok);
        req = 2'b00;
        wait_idle();
        check("hold_overrun", {31'd0, overrun}, 32'd1);
        check("hold_grant",   {30'd0, grant},   32'd0);
        clr_pulse();
`endif

        // Overrun set and clr_overrun on the same clock: set wins.
        req = 2'b01;
`ifdef FRAME_SCHED_TIMEOUT_EN
        exp_q.push_back('{2'b01, TMO});
        wait_grant(ok);
        req = 2'b00;
        repeat (TMO - 1) @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("set_over_clr", {31'd0, overrun}, 32'd1);
        wait_idle();
`else
        exp_q.push_back('{2'b01, 22});
        wait_grant(ok);
        req = 2'b00;
        wait_close_m1();
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("set_over_clr", {31'd0, overrun}, 32'd1);
`endif
        clr_pulse();

        // Reset in the middle of a grant; nothing until the next window open.
        req = 2'b01;
        exp_q.push_back('{2'b01, 4});
        wait_grant(ok);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_grant", {30'd0, grant}, 32'd0);
        check("rst_mid_busy",  {31'd0, busy},  32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        early = 1'b0;
        for (int n = 0; n < BOUND && frame_tick !== 1'b1; n++) begin
            @(negedge clk);
            if (grant != 2'b00 && frame_tick !== 1'b1) early = 1'b1;
        end
        check("no_grant_before_open", {31'd0, early}, 32'd0);
        exp_q.push_back('{2'b01, 5});
        serve(5, 1'b0);
        req = 2'b00;
        wait_idle();
        check("final_overrun", {31'd0, overrun}, 32'd0);

        repeat (3) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 32'd0);
        check("grant_onehot", onehot_bad, 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_update_sched.md
FRAME_UPDATE_SCHED -- requirements
Module: frame_update_sched

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 Parameter V_TOTAL, default 525, lines per frame.
REQ-003 Parameter V_ACTIVE, default 480, visible lines; blanking window is lines V_ACTIVE..V_TOTAL-1.
REQ-004 Parameter TIMEOUT, default 1024, maximum grant length in clocks.
REQ-005 clk  in  1  pixel clock; single clock domain.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 h_count  in  16  horizontal pixel counter, 0..H_TOTAL-1.
REQ-008 v_count  in  16  vertical line counter, 0..V_TOTAL-1.
REQ-009 req  in  2  per-player position-update request, level, bit0 = player 0.
REQ-010 done  in  2  per-player update-complete strobe, one clock.
REQ-011 clr_overrun  in  1  clears the overrun flag.
REQ-012 grant  out  2  one-hot-or-zero grant to update shared position registers.
REQ-013 frame_tick  out  1  one-clock pulse at blanking-window open.
REQ-014 busy  out  1  high while the FSM is outside IDLE.
REQ-015 overrun  out  1  sticky error flag.

Function
REQ-016 Window open SHALL be the cycle with h_count==0 and v_count==V_ACTIVE; frame_tick SHALL assert on the following clock (1-cycle latency).
REQ-017 Window close SHALL be the cycle with h_count==H_TOTAL-1 and v_count==V_TOTAL-1.
REQ-018 FSM states SHALL be IDLE, ARB, GRANT, DRAIN.
REQ-019 IDLE->ARB on window open; pending[1:0] SHALL latch req at that cycle.
REQ-020 ARB: if pending is zero -> DRAIN; otherwise select one bit round-robin, set grant next clock, go to GRANT.
REQ-021 Round-robin pointer SHALL favour the player not served last; it persists across frames and resets to player 0.
REQ-022 GRANT: on done for the granted player, clear grant and that pending bit, go to ARB.
REQ-023 done for a non-granted player SHALL be ignored.
REQ-024 Each player SHALL receive at most one grant per frame; requests rising after window open wait for the next frame.
REQ-025 DRAIN: wait for window close, then IDLE.
REQ-026 At window close in any state, grant SHALL drop on the next clock and the FSM SHALL go to IDLE; overrun SHALL set if grant was active or pending was nonzero.
REQ-027 Window close and done in the same cycle: done is accepted, no overrun for that player.
REQ-028 overrun SHALL clear on clr_overrun; set has priority over clear in the same cycle.
REQ-029 grant SHALL never have more than one bit set.

Reset
REQ-030 While rst_n is low: state IDLE, grant 0, frame_tick 0, busy 0, overrun 0, pending 0, pointer 0, timeout counter 0.
REQ-031 Reset deassertion mid-frame SHALL leave the FSM in IDLE until the next window open.

Configuration
REQ-032 Macro FRAME_SCHED_TIMEOUT_EN defined: a counter SHALL run during GRANT; on reaching TIMEOUT clocks without done, grant SHALL drop, that pending bit SHALL clear, overrun SHALL set, FSM SHALL go to ARB.
REQ-033 Macro undefined: no timeout counter; grant is held until done or window close.

Structure
REQ-034 Package vga_tag_pkg SHALL hold H_TOTAL, V_TOTAL, V_ACTIVE defaults and the FSM state typedef.
REQ-035 Sub-module rr_arbiter_2 SHALL implement the 2-way round-robin select and pointer update.

Verification
REQ-036 req=2'b01 before window open, done 10 clocks after grant -> grant=01 for 10 clocks, frame_tick one pulse, FSM ends in DRAIN, overrun=0.
REQ-037 req=2'b11 for 3 frames -> grant order P0,P1 / P0,P1 / P0,P1 following pointer, never both bits set.
REQ-038 req=01 with no done, macro defined, TIMEOUT=16 -> grant drops after 16 clocks, overrun=1; clr_overrun -> overrun=0.
REQ-039 Same stimulus, macro undefined -> grant held until window close, then drops, overrun=1.
REQ-040 rst_n pulsed low during GRANT -> grant=0 immediately, no grant until next window open.
REQ-041 done asserted on the window-close cycle -> accepted, overrun stays 0.
